// File: rtl/perf_counter_bank.sv
// Bank of memory-mapped event counters with a global enable/clear control word.
// Reads and writes are answered with a registered one-cycle ack.
module perf_counter_bank #(
    parameter int          NUM_CH      = 8,
    parameter int          CNT_W       = 16,
    parameter logic [15:0] BASE_ADDR   = 16'hFFC0,
    parameter bit          SATURATE    = 1'b0,
    parameter bit          CLR_ON_READ = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] event_inc,
    input  logic              req,
    input  logic              we,
    input  logic [15:0]       addr,
    input  logic [15:0]       wdata,
    output logic              hit,
    output logic              ack,
    output logic [15:0]       rdata,
    output logic [NUM_CH-1:0] ovf
);

    localparam logic [14:0]      CTRL_IDX = 15'(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt [NUM_CH];
    logic [NUM_CH-1:0]  r_ovf;
    logic               r_en;

    logic [14:0]        w_idx;
    logic               w_acc;
    logic               w_ctrl_sel;
    logic               w_clear_all;
    logic [NUM_CH-1:0]  w_sel;
    logic [NUM_CH-1:0]  w_wr;
    logic [NUM_CH-1:0]  w_clr;
    logic [NUM_CH-1:0]  w_inc;
    logic [15:0]        w_rd_val;
    logic               w_unused;

    // Word index relative to the window base; byte bit 0 does not take part.
    assign w_idx       = addr[15:1] - BASE_ADDR[15:1];
    assign hit         = (addr >= BASE_ADDR) && (w_idx <= CTRL_IDX);
    assign w_acc       = (r_state == S_IDLE) && req && hit;
    assign w_ctrl_sel  = (w_idx == CTRL_IDX);
    assign w_clear_all = w_acc && we && w_ctrl_sel && wdata[1];
    assign w_inc       = {NUM_CH{r_en}} & event_inc;
    assign w_wr        = {NUM_CH{w_acc && we}} & w_sel;
    assign w_clr       = {NUM_CH{w_clear_all}}
                       | ({NUM_CH{w_acc && !we && CLR_ON_READ}} & w_sel);
    assign w_unused    = ^{addr[0], wdata};
    assign ovf         = r_ovf;

    always_comb begin
        w_sel    = '0;
        w_rd_val = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_idx == 15'(i)) begin
                w_sel[i]             = 1'b1;
                w_rd_val[CNT_W-1:0]  = r_cnt[i];
            end
        end
        if (w_ctrl_sel) begin
            w_rd_val[0] = r_en;
        end
    end

    // Counter bank: write beats clear, clear beats increment (but keeps a coincident event).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
            r_ovf <= '0;
            r_en  <= 1'b1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wr[i]) begin
                    r_cnt[i] <= wdata[CNT_W-1:0];
                end else if (w_clr[i]) begin
                    r_cnt[i] <= CNT_W'(w_inc[i]);
                end else if (w_inc[i]) begin
                    if (r_cnt[i] == CNT_MAX) begin
                        r_cnt[i] <= SATURATE ? CNT_MAX : '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end
                if (w_inc[i] && !w_wr[i] && !w_clr[i] && (r_cnt[i] == CNT_MAX)) begin
                    r_ovf[i] <= 1'b1;
                end else if (w_clear_all || w_wr[i]) begin
                    r_ovf[i] <= 1'b0;
                end
            end
            if (w_acc && we && w_ctrl_sel) begin
                r_en <= wdata[0];
            end
        end
    end

    // Access FSM: the ack cycle never re-services a still-asserted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            ack     <= 1'b0;
            rdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_state <= S_RESP;
                        ack     <= 1'b1;
                        rdata   <= we ? 16'h0000 : w_rd_val;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    ack     <= 1'b0;
                    rdata   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    ack     <= 1'b0;
                    rdata   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Randomized bench for perf_counter_bank: a wrap/no-clear and a saturate/clear-on-read
// instance share stimulus and are checked against an array-based reference model.
module tb_perf_counter_bank;

    localparam int          NCH  = 8;
    localparam int          CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;
    localparam logic [15:0] BASE = 16'hFFC0;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] event_inc = '0;
    logic           req = 1'b0;
    logic           we = 1'b0;
    logic [15:0]    addr = 16'h0000;
    logic [15:0]    wdata = 16'h0000;
    logic           hit_a, ack_a, hit_b, ack_b;
    logic [15:0]    rdata_a, rdata_b;
    logic [NCH-1:0] ovf_a, ovf_b;

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .BASE_ADDR(BASE),
                        .SATURATE(1'b0), .CLR_ON_READ(1'b0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .event_inc(event_inc), .req(req), .we(we),
        .addr(addr), .wdata(wdata), .hit(hit_a), .ack(ack_a), .rdata(rdata_a), .ovf(ovf_a));

    perf_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .BASE_ADDR(BASE),
                        .SATURATE(1'b1), .CLR_ON_READ(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .event_inc(event_inc), .req(req), .we(we),
        .addr(addr), .wdata(wdata), .hit(hit_b), .ack(ack_b), .rdata(rdata_b), .ovf(ovf_b));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: index 0 = wrap/no-clear instance, 1 = saturate/clear-on-read instance.
    int m_cnt [2][NCH];
    bit m_ovf [2][NCH];
    bit m_en;
    bit m_busy;
    bit e_ack;
    bit e_read;
    int e_rd [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < NCH; i++) begin
                m_cnt[c][i] = 0;
                m_ovf[c][i] = 1'b0;
            end
        end
        m_en   = 1'b1;
        m_busy = 1'b0;
        e_ack  = 1'b0;
        e_read = 1'b0;
    endtask

    function automatic logic [31:0] ovf_vec(input int c);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++) v[i] = m_ovf[c][i];
        return v;
    endfunction

    task automatic drive(input bit r, input bit w, input logic [15:0] a,
                         input logic [15:0] d, input logic [NCH-1:0] ev);
        req = r; we = w; addr = a; wdata = d; event_inc = ev;
    endtask

    // One clock: predict from current inputs, clock, then compare registered outputs.
    task automatic step();
        int  off, idx, nv;
        bit  hit_e, acc, clr_all, inc, wr, clr;
        #1;
        off   = int'(addr) - int'(BASE);
        hit_e = (off >= 0) && ((off / 2) <= NCH);
        chk("hit_a", 32'(hit_a), 32'(hit_e));
        chk("hit_b", 32'(hit_b), 32'(hit_e));
        idx    = hit_e ? off / 2 : -1;
        acc    = !m_busy && req && hit_e;
        e_ack  = acc;
        e_read = acc && !we;
        for (int c = 0; c < 2; c++) begin
            if (idx >= 0 && idx < NCH) e_rd[c] = m_cnt[c][idx];
            else                       e_rd[c] = int'(m_en);
        end
        clr_all = acc && we && (idx == NCH) && wdata[1];
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < NCH; i++) begin
                inc = m_en && event_inc[i];
                wr  = acc && we && (idx == i);
                clr = clr_all || (acc && !we && (c == 1) && (idx == i));
                if (wr) begin
                    m_cnt[c][i] = int'(wdata) % (CMAX + 1);
                    m_ovf[c][i] = 1'b0;
                end else if (clr) begin
                    m_cnt[c][i] = int'(inc);
                    if (clr_all) m_ovf[c][i] = 1'b0;
                end else if (inc) begin
                    nv = m_cnt[c][i] + 1;
                    if (nv > CMAX) begin
                        m_ovf[c][i] = 1'b1;
                        nv = (c == 1) ? CMAX : 0;
                    end
                    m_cnt[c][i] = nv;
                end
            end
        end
        if (acc && we && idx == NCH) m_en = wdata[0];
        m_busy = acc;
        @(posedge clk);
        #1;
        chk("ack_a", 32'(ack_a), 32'(e_ack));
        chk("ack_b", 32'(ack_b), 32'(e_ack));
        if (e_read) begin
            chk("rdata_a", 32'(rdata_a), 32'(e_rd[0]));
            chk("rdata_b", 32'(rdata_b), 32'(e_rd[1]));
        end else if (!e_ack) begin
            chk("rdata_idle_a", 32'(rdata_a), 32'h0);
            chk("rdata_idle_b", 32'(rdata_b), 32'h0);
        end
        chk("ovf_a", 32'(ovf_a), ovf_vec(0));
        chk("ovf_b", 32'(ovf_b), ovf_vec(1));
    endtask

    task automatic rand_step();
        int k, v, n;
        req = ($urandom_range(0, 99) < 60);
        we  = ($urandom_range(0, 3) == 0);
        k   = $urandom_range(0, 9);
        if (k < 7) begin
            n    = $urandom_range(0, NCH);
            addr = 16'(int'(BASE) + 2 * n + $urandom_range(0, 1));
        end else if (k == 7) begin
            addr = 16'h1000;
        end else if (k == 8) begin
            v = $urandom_range(0, 3);
            addr = (v == 0) ? 16'hFFBE : (v == 1) ? 16'hFFBF : (v == 2) ? 16'hFFD2 : 16'hFFD3;
        end else begin
            addr = 16'($urandom);
        end
        if (addr[15:1] == 15'(int'(BASE[15:1]) + NCH)) begin
            v = $urandom_range(0, 9);
            wdata = (v == 0) ? 16'h0000 : (v == 1) ? 16'h0003 : (v == 2) ? 16'h0002 : 16'h0001;
        end else begin
            wdata = 16'($urandom);
        end
        event_inc = NCH'($urandom);
        step();
    endtask

    initial begin
        logic [3:0] ack_pat;
        model_reset();
        #2;
        chk("rst_ack_a", 32'(ack_a), 32'h0);
        chk("rst_rdata_a", 32'(rdata_a), 32'h0);
        chk("rst_ovf_a", 32'(ovf_a), 32'h0);
        chk("rst_ovf_b", 32'(ovf_b), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Five pulses on channel 2, then read it back.
        for (int p = 0; p < 5; p++) begin
            drive(1'b0, 1'b0, 16'h0000, 16'h0000, NCH'(4)); step();
            drive(1'b0, 1'b0, 16'h0000, 16'h0000, '0);     step();
        end
        drive(1'b1, 1'b0, 16'hFFC4, 16'h0000, '0); step();
        chk("t1_rdata_a", 32'(rdata_a), 32'h5);
        chk("t1_ack_a", 32'(ack_a), 32'h1);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, '0); step();

        // 17 events on channel 0: wrap gives 1, saturate holds 0xF; both flag overflow.
        for (int p = 0; p < 17; p++) begin
            drive(1'b0, 1'b0, 16'h0000, 16'h0000, NCH'(1)); step();
        end
        drive(1'b1, 1'b0, 16'hFFC0, 16'h0000, '0); step();
        chk("t2_wrap_a", 32'(rdata_a), 32'h1);
        chk("t2_sat_b", 32'(rdata_b), 32'hF);
        chk("t2_ovf_a", 32'(ovf_a[0]), 32'h1);
        chk("t2_ovf_b", 32'(ovf_b[0]), 32'h1);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, '0); step();

        // Clear-on-read with a coincident event: reads 7, then 1.
        drive(1'b1, 1'b1, 16'hFFC2, 16'h0007, '0); step();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, '0); step();
        drive(1'b1, 1'b0, 16'hFFC2, 16'h0000, NCH'(2)); step();
        chk("t3_rd7_b", 32'(rdata_b), 32'h7);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, '0); step();
        drive(1'b1, 1'b0, 16'hFFC2, 16'h0000, '0); step();
        chk("t3_rd1_b", 32'(rdata_b), 32'h1);
        chk("t3_rd8_a", 32'(rdata_a), 32'h8);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, '0); step();

        // Disable, events are ignored; then re-enable with clear_all.
        drive(1'b1, 1'b1, 16'hFFD0, 16'h0000, '0); step();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, '1); step();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, '1); step();
        drive(1'b1, 1'b0, 16'hFFD0, 16'h0000, '0); step();
        chk("t4_ctrl_off", 32'(rdata_a), 32'h0);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, '0); step();
        drive(1'b1, 1'b1, 16'hFFD0, 16'h0003, '0); step();
        chk("t4_clr_ovf_a", 32'(ovf_a), 32'h0);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, '1); step();
        drive(1'b1, 1'b0, 16'hFFC6, 16'h0000, '0); step();
        chk("t4_resume_a", 32'(rdata_a), 32'h1);

        // Request held four cycles, then an out-of-window request.
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, '0); step();
        ack_pat = '0;
        for (int p = 0; p < 4; p++) begin
            ack_pat[3 - p] = ack_a;
            drive(1'b1, 1'b0, 16'hFFC6, 16'h0000, '0); step();
        end
        chk("t5_ack_pattern", 32'(ack_pat), 32'b0101);
        for (int p = 0; p < 3; p++) begin
            drive(1'b1, 1'b0, 16'h1000, 16'h0000, '0); step();
            chk("t5_nohit_ack", 32'(ack_a), 32'h0);
        end
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, '0); step();

        for (int n = 0; n < 3000; n++) rand_step();

        // Asynchronous reset in the middle of a response cycle.
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, '0); step();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, '1); step();
        drive(1'b1, 1'b0, 16'hFFC4, 16'h0000, '0); step();
        chk("t6_pre_ack", 32'(ack_a), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_ack_a", 32'(ack_a), 32'h0);
        chk("t6_ack_b", 32'(ack_b), 32'h0);
        chk("t6_rdata_a", 32'(rdata_a), 32'h0);
        chk("t6_rdata_b", 32'(rdata_b), 32'h0);
        model_reset();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            drive(1'b1, 1'b0, 16'(int'(BASE) + 2 * i), 16'h0000, '0); step();
            chk("t6_cnt_zero_a", 32'(rdata_a), 32'h0);
            drive(1'b0, 1'b0, 16'h0000, 16'h0000, '0); step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
